// File: rtl/mem_dp_clr.sv
// True dual-port byte-write RAM with a post-reset clear sequencer and per-port valid strobes.
// Optional collision counter output enabled by defining MEM_DP_COLLISION_CNT_EN.

module mem_dp_clr_rdpipe #(
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_in,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);
    logic [LAT:1]        vld_pipe;
    logic [LAT:1][W-1:0] dat_pipe;

    // Data stages only load on a valid beat so dout holds between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= vld_in;
            if (vld_in) dat_pipe[1] <= din;
            for (int s = 2; s <= LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign dout  = dat_pipe[LAT];
    assign valid = vld_pipe[LAT];
endmodule

module mem_dp_clr #(
    parameter int NUM_COL      = 4,
    parameter int COL_WIDTH    = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            busy,
    input  logic                            enaA,
    input  logic [NUM_COL-1:0]              weA,
    input  logic [ADDR_WIDTH-1:0]           addrA,
    input  logic [NUM_COL*COL_WIDTH-1:0]    dinA,
    output logic [NUM_COL*COL_WIDTH-1:0]    doutA,
    output logic                            validA,
    input  logic                            enaB,
    input  logic [NUM_COL-1:0]              weB,
    input  logic [ADDR_WIDTH-1:0]           addrB,
    input  logic [NUM_COL*COL_WIDTH-1:0]    dinB,
    output logic [NUM_COL*COL_WIDTH-1:0]    doutB,
    output logic                            validB
`ifdef MEM_DP_COLLISION_CNT_EN
    ,
    output logic [15:0]                     coll_cnt
`endif
);
    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                              state;
    logic [ADDR_WIDTH-1:0]               clr_ptr;
    logic [DATA_WIDTH-1:0]               mem [DEPTH];

    logic [1:0]                          ena, acc, valid;
    logic [1:0][NUM_COL-1:0]             we;
    logic [1:0][ADDR_WIDTH-1:0]          addr;
    logic [1:0][DATA_WIDTH-1:0]          din, rd_word, dout;

    assign ena  = {enaB, enaA};
    assign we   = {weB, weA};
    assign addr = {addrB, addrA};
    assign din  = {dinB, dinA};
    assign acc  = ena & {2{(state == READY) && !rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == '1) begin
                state <= READY;
                busy  <= 1'b0;
            end
        end
    end

    // Port B is applied first so port A's columns override it on a shared address.
    always_ff @(posedge clk) begin
        if (state == CLEAR && !rst) begin
            mem[clr_ptr] <= '0;
        end else begin
            for (int p = 1; p >= 0; p--) begin
                if (acc[p]) begin
                    for (int c = 0; c < NUM_COL; c++) begin
                        if (we[p][c])
                            mem[addr[p]][c*COL_WIDTH +: COL_WIDTH] <= din[p][c*COL_WIDTH +: COL_WIDTH];
                    end
                end
            end
        end
    end

    // Write-first merges only this port's own columns; the other port's write stays invisible.
    always_comb begin
        rd_word = '0;
        for (int p = 0; p < 2; p++) begin
            rd_word[p] = mem[addr[p]];
            if (RDW_MODE != 0) begin
                for (int c = 0; c < NUM_COL; c++) begin
                    if (we[p][c])
                        rd_word[p][c*COL_WIDTH +: COL_WIDTH] = din[p][c*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        mem_dp_clr_rdpipe #(
            .W   (DATA_WIDTH),
            .LAT (READ_LATENCY)
        ) u_rdpipe (
            .clk    (clk),
            .rst    (rst),
            .vld_in (acc[p]),
            .din    (rd_word[p]),
            .dout   (dout[p]),
            .valid  (valid[p])
        );
    end

    assign doutA  = dout[0];
    assign doutB  = dout[1];
    assign validA = valid[0];
    assign validB = valid[1];

`ifdef MEM_DP_COLLISION_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            coll_cnt <= '0;
        else if (acc[0] && acc[1] && addrA == addrB && (|weA || |weB) && coll_cnt != 16'hFFFF)
            coll_cnt <= coll_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mem_dp_clr.sv
// Directed bench: two instances (latency 1 read-first, latency 2 write-first) on shared stimulus.
module tb_mem_dp_clr;
    logic        clk = 1'b0;
    logic        rst;
    logic        ea, eb;
    logic [3:0]  wa, wb, aa, ab;
    logic [31:0] da, db;
    logic        busy0, busy1, va0, vb0, va1, vb1;
    logic [31:0] doa0, dob0, doa1, dob1;
    logic [15:0] cc0, cc1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_dp_clr #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .busy(busy0),
        .enaA(ea), .weA(wa), .addrA(aa), .dinA(da), .doutA(doa0), .validA(va0),
        .enaB(eb), .weB(wb), .addrB(ab), .dinB(db), .doutB(dob0), .validB(vb0)
`ifdef MEM_DP_COLLISION_CNT_EN
        , .coll_cnt(cc0)
`endif
    );

    mem_dp_clr #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .busy(busy1),
        .enaA(ea), .weA(wa), .addrA(aa), .dinA(da), .doutA(doa1), .validA(va1),
        .enaB(eb), .weB(wb), .addrB(ab), .dinB(db), .doutB(dob1), .validB(vb1)
`ifdef MEM_DP_COLLISION_CNT_EN
        , .coll_cnt(cc1)
`endif
    );

`ifndef MEM_DP_COLLISION_CNT_EN
    assign cc0 = '0;
    assign cc1 = '0;
`endif

    typedef struct {
        logic ea; logic [3:0] wa; logic [3:0] aa; logic [31:0] da;
        logic eb; logic [3:0] wb; logic [3:0] ab; logic [31:0] db;
        logic v0a; logic [31:0] x0a; logic v0b; logic [31:0] x0b;
        logic v1a; logic [31:0] x1a; logic v1b; logic [31:0] x1b;
        logic c1;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        ea = 0; wa = 0; aa = 0; da = 0;
        eb = 0; wb = 0; ab = 0; db = 0;
    endtask

    // Counts busy cycles after rst falls while hammering both ports with writes to words 0/1.
    task automatic count_busy(input string name);
        int n;
        n = 0;
        ea = 1; wa = 4'hF; aa = 4'd0; da = 32'hDEADBEEF;
        eb = 1; wb = 4'hF; ab = 4'd1; db = 32'hCAFEF00D;
        while (busy0 && n < 40) begin
            step();
            n++;
            if (va0 || vb0 || va1 || vb1 || busy1 !== busy0) begin
                chk({name, "_busy_quiet"}, {busy1, va0, vb0, va1, vb1}, {busy0, 4'b0});
            end
        end
        idle();
        chk({name, "_busy_cycles"}, n, 16);
    endtask

    initial begin
        vec[0]  = '{1,4'hF,4'd5,32'h11223344, 1,4'h0,4'd0,32'h0, 1,32'h0,1,32'h0, 0,32'h0,0,32'h0, 1};
        vec[1]  = '{1,4'h5,4'd5,32'hAABBCCDD, 1,4'h0,4'd1,32'h0, 1,32'h11223344,1,32'h0, 1,32'h11223344,1,32'h0, 1};
        vec[2]  = '{1,4'h0,4'd5,32'h0, 0,4'h0,4'd0,32'h0, 1,32'h11BB33DD,0,32'h0, 1,32'h11BB33DD,1,32'h0, 1};
        vec[3]  = '{1,4'hF,4'd3,32'hFFFFFFFF, 0,4'h0,4'd0,32'h0, 1,32'h0,0,32'h0, 1,32'h11BB33DD,0,32'h0, 1};
        vec[4]  = '{1,4'h3,4'd7,32'hAAAAAAAA, 1,4'h6,4'd7,32'hBBBBBBBB, 1,32'h0,1,32'h0, 1,32'hFFFFFFFF,0,32'h0, 1};
        vec[5]  = '{1,4'h0,4'd7,32'h0, 1,4'h0,4'd3,32'h0, 1,32'h00BBAAAA,1,32'hFFFFFFFF, 1,32'h0,1,32'h0, 0};
        vec[6]  = '{1,4'hF,4'd9,32'h12345678, 1,4'h0,4'd9,32'h0, 1,32'h0,1,32'h0, 1,32'h00BBAAAA,1,32'hFFFFFFFF, 1};
        vec[7]  = '{0,4'h0,4'd0,32'h0, 0,4'h0,4'd0,32'h0, 0,32'h0,0,32'h0, 1,32'h12345678,1,32'h0, 1};
        vec[8]  = '{1,4'hF,4'd0,32'h00000A00, 1,4'hF,4'd1,32'h00000B01, 1,32'h0,1,32'h0, 0,32'h0,0,32'h0, 1};
        vec[9]  = '{1,4'hF,4'd2,32'h00000C02, 0,4'h0,4'd0,32'h0, 1,32'h0,0,32'h0, 1,32'h00000A00,1,32'h00000B01, 1};
        vec[10] = '{0,4'h0,4'd0,32'h0, 1,4'h0,4'd0,32'h0, 0,32'h0,1,32'h00000A00, 1,32'h00000C02,0,32'h0, 1};
        vec[11] = '{0,4'h0,4'd0,32'h0, 1,4'h0,4'd1,32'h0, 0,32'h0,1,32'h00000B01, 0,32'h0,1,32'h00000A00, 1};
        vec[12] = '{0,4'h0,4'd0,32'h0, 1,4'h0,4'd2,32'h0, 0,32'h0,1,32'h00000C02, 0,32'h0,1,32'h00000B01, 1};
        vec[13] = '{0,4'h0,4'd0,32'h0, 0,4'h0,4'd0,32'h0, 0,32'h0,0,32'h0, 0,32'h0,1,32'h00000C02, 1};
        vec[14] = '{0,4'h0,4'd0,32'h0, 0,4'h0,4'd0,32'h0, 0,32'h0,0,32'h0, 0,32'h0,0,32'h0, 1};

        rst = 1;
        idle();
        step();
        step();
        chk("rst_busy", {busy0, busy1}, 2'b11);
        chk("rst_valid", {va0, vb0, va1, vb1}, 4'b0);
        chk("rst_dout0", doa0 | dob0, 32'h0);
        chk("rst_dout1", doa1 | dob1, 32'h0);
`ifdef MEM_DP_COLLISION_CNT_EN
        chk("rst_coll", {cc0, cc1}, 32'h0);
`endif

        // Abort the first clear at cycle 8, then a full restart must follow.
        rst = 0;
        for (int i = 0; i < 8; i++) step();
        chk("midclear_busy", {busy0, busy1}, 2'b11);
        rst = 1;
        step();
        rst = 0;
        count_busy("midclear");

        for (int i = 0; i < NV; i++) begin
            ea = vec[i].ea; wa = vec[i].wa; aa = vec[i].aa; da = vec[i].da;
            eb = vec[i].eb; wb = vec[i].wb; ab = vec[i].ab; db = vec[i].db;
            step();
            chk($sformatf("v%0d_d0_va", i), va0, vec[i].v0a);
            chk($sformatf("v%0d_d0_vb", i), vb0, vec[i].v0b);
            chk($sformatf("v%0d_d1_va", i), va1, vec[i].v1a);
            chk($sformatf("v%0d_d1_vb", i), vb1, vec[i].v1b);
            if (vec[i].v0a) chk($sformatf("v%0d_d0_da", i), doa0, vec[i].x0a);
            if (vec[i].v0b) chk($sformatf("v%0d_d0_db", i), dob0, vec[i].x0b);
            if (vec[i].c1 && vec[i].v1a) chk($sformatf("v%0d_d1_da", i), doa1, vec[i].x1a);
            if (vec[i].c1 && vec[i].v1b) chk($sformatf("v%0d_d1_db", i), dob1, vec[i].x1b);
        end
        idle();
        chk("hold_d0_db", dob0, 32'h00000C02);
        chk("hold_d1_db", dob1, 32'h00000C02);
`ifdef MEM_DP_COLLISION_CNT_EN
        chk("coll_cnt0", cc0, 16'd2);
        chk("coll_cnt1", cc1, 16'd2);
`endif

        // Fill the array, confirm it, then a single-cycle reset must zero it again.
        for (int i = 0; i < 16; i++) begin
            ea = 1; wa = 4'hF; aa = 4'(i); da = 32'hDEADBEEF;
            step();
        end
        ea = 1; wa = 4'h0; aa = 4'd4;
        step();
        idle();
        chk("fill_d0", doa0, 32'hDEADBEEF);
        step();
        chk("fill_d1", doa1, 32'hDEADBEEF);

        rst = 1;
        step();
        rst = 0;
`ifdef MEM_DP_COLLISION_CNT_EN
        chk("pulse_coll", {cc0, cc1}, 32'h0);
`endif
        count_busy("pulse");

        for (int i = 0; i < 16; i++) begin
            ea = 1; wa = 4'h0; aa = 4'(i);
            step();
            chk($sformatf("clr%0d_d0", i), {31'b0, va0} | doa0, 32'h1);
            if (i > 0) chk($sformatf("clr%0d_d1", i - 1), {31'b0, va1} | doa1, 32'h1);
        end
        idle();
        step();
        chk("clr15_d1", {31'b0, va1} | doa1, 32'h1);
        chk("clr_idle_d0", {31'b0, va0}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
